// File: rtl/instr_controller.sv
// Multi-cycle instruction sequencer: decodes {opcode,op}, steps a Moore FSM through
// the datapath control sequence, handles the memory handshake with timeout and counts retired instructions.
module instr_controller #(
    parameter int EN_MEM  = 1,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic [2:0]       opcode,
    input  logic [1:0]       op,
    input  logic             mem_rdy,
    output logic             w,
    output logic [2:0]       nsel,
    output logic [3:0]       vsel,
    output logic             write,
    output logic             loada,
    output logic             loadb,
    output logic             asel,
    output logic             bsel,
    output logic             loads,
    output logic             loadc,
    output logic             load_addr,
    output logic             mem_req,
    output logic             mem_we,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_GET_D, S_SHIFT, S_EXEC,
        S_WRITE_REG, S_ADDR, S_STR_C, S_MEM_RD, S_MEM_WR, S_WRITE_MEM, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        I_MOV_IMM, I_MOV_SHIFT, I_ADD, I_CMP, I_AND, I_MVN, I_LDR, I_STR, I_HALT, I_ILLEGAL
    } instr_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    function automatic instr_t decode_instr(input logic [4:0] code);
        case (code)
            5'b11010: return I_MOV_IMM;
            5'b11000: return I_MOV_SHIFT;
            5'b10100: return I_ADD;
            5'b10101: return I_CMP;
            5'b10110: return I_AND;
            5'b10111: return I_MVN;
            5'b01100: return (EN_MEM != 0) ? I_LDR : I_ILLEGAL;
            5'b10000: return (EN_MEM != 0) ? I_STR : I_ILLEGAL;
            5'b11100: return I_HALT;
            default:  return I_ILLEGAL;
        endcase
    endfunction

    state_t           r_state;
    state_t           w_next;
    logic [4:0]       r_code;
    logic [7:0]       r_wcnt;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    instr_t           w_instr;
    logic             w_retire;
    logic             w_err_set;
    logic             w_in_mem;
    logic             w_timeout;

    assign w_instr   = decode_instr(r_code);
    assign w_in_mem  = (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_timeout = w_in_mem && !mem_rdy && (r_wcnt == TO_LAST);
    assign err       = r_err;
    assign instr_cnt = r_cnt;

    // Instruction code is captured every WAIT cycle so the s=1 cycle's code is held for the whole sequence.
    always_ff @(posedge clk) begin
        if (r_state == S_WAIT) r_code <= {opcode, op};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_wcnt  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err_set;
            if (w_retire) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_in_mem && !mem_rdy) r_wcnt <= r_wcnt + 8'd1;
            else                      r_wcnt <= '0;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_retire  = 1'b0;
        w_err_set = 1'b0;
        w         = 1'b0;
        nsel      = 3'b000;
        vsel      = 4'b0000;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        loads     = 1'b0;
        loadc     = 1'b0;
        load_addr = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        halted    = 1'b0;
        case (r_state)
            S_WAIT: begin
                w = 1'b1;
                if (s) w_next = S_DECODE;
            end
            S_DECODE: begin
                case (w_instr)
                    I_MOV_IMM:                        w_next = S_WRITE_IMM;
                    I_MOV_SHIFT, I_MVN:               w_next = S_GET_B;
                    I_ADD, I_CMP, I_AND, I_LDR, I_STR: w_next = S_GET_A;
                    I_HALT: begin
                        w_next   = S_HALT;
                        w_retire = 1'b1;
                    end
                    default: begin
                        w_next    = S_WAIT;
                        w_err_set = 1'b1;
                    end
                endcase
            end
            S_WRITE_IMM: begin
                nsel = 3'b100; vsel = 4'b0100; write = 1'b1;
                w_next = S_WAIT; w_retire = 1'b1;
            end
            S_GET_A: begin
                nsel = 3'b100; loada = 1'b1;
                w_next = (w_instr == I_LDR || w_instr == I_STR) ? S_ADDR : S_GET_B;
            end
            S_GET_B: begin
                nsel = 3'b001; loadb = 1'b1;
                w_next = (w_instr == I_MOV_SHIFT || w_instr == I_MVN) ? S_SHIFT : S_EXEC;
            end
            S_SHIFT: begin
                asel = 1'b1; loadc = 1'b1; w_next = S_WRITE_REG;
            end
            S_EXEC: begin
                if (w_instr == I_CMP) begin
                    loads = 1'b1; w_next = S_WAIT; w_retire = 1'b1;
                end else begin
                    loadc = 1'b1; w_next = S_WRITE_REG;
                end
            end
            S_WRITE_REG: begin
                nsel = 3'b010; vsel = 4'b0001; write = 1'b1;
                w_next = S_WAIT; w_retire = 1'b1;
            end
            S_ADDR: begin
                bsel = 1'b1; load_addr = 1'b1;
                w_next = (w_instr == I_LDR) ? S_MEM_RD : S_GET_D;
            end
            S_GET_D: begin
                nsel = 3'b010; loadb = 1'b1; w_next = S_STR_C;
            end
            S_STR_C: begin
                asel = 1'b1; loadc = 1'b1; w_next = S_MEM_WR;
            end
            // A ready on the final wait cycle still completes the access.
            S_MEM_RD: begin
                mem_req = 1'b1;
                if (mem_rdy) w_next = S_WRITE_MEM;
                else if (w_timeout) begin
                    w_next = S_WAIT; w_err_set = 1'b1;
                end
            end
            S_MEM_WR: begin
                mem_req = 1'b1; mem_we = 1'b1;
                if (mem_rdy) begin
                    w_next = S_WAIT; w_retire = 1'b1;
                end else if (w_timeout) begin
                    w_next = S_WAIT; w_err_set = 1'b1;
                end
            end
            S_WRITE_MEM: begin
                nsel = 3'b010; vsel = 4'b1000; write = 1'b1;
                w_next = S_WAIT; w_retire = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: w_next = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_instr_controller.sv
// Scoreboard bench: an instruction-level model expands each issued instruction into its
// expected per-cycle control outputs; a monitor compares them against two DUTs (EN_MEM=1 and EN_MEM=0).
module tb_instr_controller;
    localparam int TIMEOUT = 15;

    // Output bundle: w, nsel[3], vsel[4], write loada loadb asel bsel loads loadc load_addr mem_req mem_we halted err
    localparam logic [19:0] P_WAIT = {1'b1, 3'b000, 4'b0000, 12'b0000_0000_0000};
    localparam logic [19:0] P_DEC  = 20'h00000;
    localparam logic [19:0] P_WIMM = {1'b0, 3'b100, 4'b0100, 12'b1000_0000_0000};
    localparam logic [19:0] P_GETA = {1'b0, 3'b100, 4'b0000, 12'b0100_0000_0000};
    localparam logic [19:0] P_GETB = {1'b0, 3'b001, 4'b0000, 12'b0010_0000_0000};
    localparam logic [19:0] P_ALUC = {1'b0, 3'b000, 4'b0000, 12'b0001_0010_0000};
    localparam logic [19:0] P_EXC  = {1'b0, 3'b000, 4'b0000, 12'b0000_0010_0000};
    localparam logic [19:0] P_CMP  = {1'b0, 3'b000, 4'b0000, 12'b0000_0100_0000};
    localparam logic [19:0] P_WREG = {1'b0, 3'b010, 4'b0001, 12'b1000_0000_0000};
    localparam logic [19:0] P_ADDR = {1'b0, 3'b000, 4'b0000, 12'b0000_1001_0000};
    localparam logic [19:0] P_GETD = {1'b0, 3'b010, 4'b0000, 12'b0010_0000_0000};
    localparam logic [19:0] P_MRD  = {1'b0, 3'b000, 4'b0000, 12'b0000_0000_1000};
    localparam logic [19:0] P_MWR  = {1'b0, 3'b000, 4'b0000, 12'b0000_0000_1100};
    localparam logic [19:0] P_WMEM = {1'b0, 3'b010, 4'b1000, 12'b1000_0000_0000};
    localparam logic [19:0] P_HALT = {1'b0, 3'b000, 4'b0000, 12'b0000_0000_0010};

    localparam int C_MOVI = 0, C_MOVS = 1, C_ADD = 2, C_CMP = 3, C_AND = 4,
                   C_MVN = 5, C_LDR = 6, C_STR = 7, C_HALT = 8, C_ILL = 9;

    typedef struct {
        bit          sel;
        logic [19:0] pat;
        logic [7:0]  cnt;
        string       nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s1 = 1'b0, s2 = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;
    logic       mem_rdy = 1'b0;

    logic       w1, write1, loada1, loadb1, asel1, bsel1, loads1, loadc1, la1, mreq1, mwe1, halt1, err1;
    logic [2:0] nsel1;
    logic [3:0] vsel1;
    logic [7:0] cnt1;
    logic       w2, write2, loada2, loadb2, asel2, bsel2, loads2, loadc2, la2, mreq2, mwe2, halt2, err2;
    logic [2:0] nsel2;
    logic [3:0] vsel2;
    logic [7:0] cnt2;

    instr_controller #(.EN_MEM(1), .TIMEOUT(TIMEOUT), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .s(s1), .opcode(opcode), .op(op), .mem_rdy(mem_rdy),
        .w(w1), .nsel(nsel1), .vsel(vsel1), .write(write1), .loada(loada1), .loadb(loadb1),
        .asel(asel1), .bsel(bsel1), .loads(loads1), .loadc(loadc1), .load_addr(la1),
        .mem_req(mreq1), .mem_we(mwe1), .halted(halt1), .err(err1), .instr_cnt(cnt1)
    );

    instr_controller #(.EN_MEM(0), .TIMEOUT(TIMEOUT), .CNT_W(8)) u_dut_nomem (
        .clk(clk), .reset(reset), .s(s2), .opcode(opcode), .op(op), .mem_rdy(mem_rdy),
        .w(w2), .nsel(nsel2), .vsel(vsel2), .write(write2), .loada(loada2), .loadb(loadb2),
        .asel(asel2), .bsel(bsel2), .loads(loads2), .loadc(loadc2), .load_addr(la2),
        .mem_req(mreq2), .mem_we(mwe2), .halted(halt2), .err(err2), .instr_cnt(cnt2)
    );

    always #5 clk = ~clk;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] m_cnt [2];
    bit         m_err [2];
    logic [4:0] cur_code;
    string      cur_nm;

    // Monitor: one expected bundle per clock while the scoreboard holds entries.
    always @(negedge clk) begin
        exp_t        x;
        logic [19:0] act;
        logic [7:0]  acnt;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            if (x.sel) begin
                act  = {w2, nsel2, vsel2, write2, loada2, loadb2, asel2, bsel2, loads2, loadc2, la2, mreq2, mwe2, halt2, err2};
                acnt = cnt2;
            end else begin
                act  = {w1, nsel1, vsel1, write1, loada1, loadb1, asel1, bsel1, loads1, loadc1, la1, mreq1, mwe1, halt1, err1};
                acnt = cnt1;
            end
            n_tests++;
            if (act !== x.pat || acnt !== x.cnt) begin
                n_fail++;
                $display("FAIL %s (dut%0d) t=%0t: got outputs=%b cnt=%0d, expected outputs=%b cnt=%0d",
                         x.nm, x.sel, $time, act, acnt, x.pat, x.cnt);
            end
        end
    end

    function automatic bit rb();
        return 1'($urandom % 2);
    endfunction

    function automatic int classify(input logic [4:0] c, input bit en_mem);
        case (c)
            5'b11010: return C_MOVI;
            5'b11000: return C_MOVS;
            5'b10100: return C_ADD;
            5'b10101: return C_CMP;
            5'b10110: return C_AND;
            5'b10111: return C_MVN;
            5'b01100: return en_mem ? C_LDR : C_ILL;
            5'b10000: return en_mem ? C_STR : C_ILL;
            5'b11100: return C_HALT;
            default:  return C_ILL;
        endcase
    endfunction

    task automatic step(input bit sel, input bit sv, input bit rdy, input bit rst, input logic [19:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        s1 = sel ? 1'b0 : sv;
        s2 = sel ? sv : 1'b0;
        {opcode, op} = cur_code;
        mem_rdy = rdy;
        reset = rst;
        x.sel = sel; x.pat = e; x.cnt = m_cnt[sel]; x.nm = cur_nm;
        sb.push_back(x);
    endtask

    task automatic retire(input bit sel);
        m_cnt[sel] = 8'((int'(m_cnt[sel]) + 1) % 256);
    endtask

    task automatic idle(input bit sel);
        cur_code = 5'($urandom);
        cur_nm = "idle";
        step(sel, 1'b0, rb(), 1'b0, P_WAIT | {19'b0, m_err[sel]});
        m_err[sel] = 1'b0;
    endtask

    // k = number of not-ready memory cycles before ready; k >= TIMEOUT means ready never arrives in time.
    task automatic mem_phase(input bit sel, input int k, input logic [19:0] pat, output bit ok);
        int n;
        n = (k >= TIMEOUT) ? TIMEOUT : k + 1;
        for (int j = 0; j < n; j++) step(sel, rb(), (j == k), 1'b0, pat);
        ok = (k < TIMEOUT);
        if (!ok) m_err[sel] = 1'b1;
    endtask

    task automatic issue(input bit sel, input logic [4:0] code, input int k, input string nm);
        bit ok;
        int c;
        c = classify(code, !sel);
        cur_code = code;
        cur_nm = nm;
        step(sel, 1'b1, rb(), 1'b0, P_WAIT | {19'b0, m_err[sel]});
        m_err[sel] = 1'b0;
        step(sel, rb(), rb(), 1'b0, P_DEC);
        case (c)
            C_MOVI: begin step(sel, rb(), rb(), 1'b0, P_WIMM); retire(sel); end
            C_MOVS, C_MVN: begin
                step(sel, rb(), rb(), 1'b0, P_GETB);
                step(sel, rb(), rb(), 1'b0, P_ALUC);
                step(sel, rb(), rb(), 1'b0, P_WREG);
                retire(sel);
            end
            C_ADD, C_AND: begin
                step(sel, rb(), rb(), 1'b0, P_GETA);
                step(sel, rb(), rb(), 1'b0, P_GETB);
                step(sel, rb(), rb(), 1'b0, P_EXC);
                step(sel, rb(), rb(), 1'b0, P_WREG);
                retire(sel);
            end
            C_CMP: begin
                step(sel, rb(), rb(), 1'b0, P_GETA);
                step(sel, rb(), rb(), 1'b0, P_GETB);
                step(sel, rb(), rb(), 1'b0, P_CMP);
                retire(sel);
            end
            C_LDR: begin
                step(sel, rb(), rb(), 1'b0, P_GETA);
                step(sel, rb(), rb(), 1'b0, P_ADDR);
                mem_phase(sel, k, P_MRD, ok);
                if (ok) begin step(sel, rb(), rb(), 1'b0, P_WMEM); retire(sel); end
            end
            C_STR: begin
                step(sel, rb(), rb(), 1'b0, P_GETA);
                step(sel, rb(), rb(), 1'b0, P_ADDR);
                step(sel, rb(), rb(), 1'b0, P_GETD);
                step(sel, rb(), rb(), 1'b0, P_ALUC);
                mem_phase(sel, k, P_MWR, ok);
                if (ok) retire(sel);
            end
            C_HALT: retire(sel);
            default: m_err[sel] = 1'b1;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, scoreboard depth %0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] legal [8];
        logic [4:0] code;
        int         k;
        legal[0] = 5'b11010; legal[1] = 5'b11000; legal[2] = 5'b10100; legal[3] = 5'b10101;
        legal[4] = 5'b10110; legal[5] = 5'b10111; legal[6] = 5'b01100; legal[7] = 5'b10000;
        m_cnt[0] = '0; m_cnt[1] = '0; m_err[0] = 1'b0; m_err[1] = 1'b0;
        cur_code = 5'b00000; cur_nm = "reset";
        repeat (3) @(posedge clk);
        step(1'b0, 1'b1, 1'b1, 1'b1, P_WAIT);
        step(1'b1, 1'b1, 1'b1, 1'b1, P_WAIT);
        idle(1'b0);

        // EN_MEM=0 instance: memory codes are illegal, ALU codes still work.
        issue(1'b1, 5'b01100, 2, "nomem_ldr");
        issue(1'b1, 5'b10000, 2, "nomem_str");
        issue(1'b1, 5'b10100, 0, "nomem_add");
        issue(1'b1, 5'b00000, 0, "nomem_illegal");
        idle(1'b1);

        issue(1'b0, 5'b11010, 0, "mov_imm");
        issue(1'b0, 5'b10100, 0, "add");
        issue(1'b0, 5'b10101, 0, "cmp");
        issue(1'b0, 5'b01100, 3, "ldr_rdy3");
        issue(1'b0, 5'b10000, 99, "str_timeout");
        issue(1'b0, 5'b10000, TIMEOUT - 1, "str_rdy_last");
        issue(1'b0, 5'b01100, TIMEOUT, "ldr_timeout");
        issue(1'b0, 5'b00000, 0, "illegal_00000");
        idle(1'b0);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) < 7) code = legal[$urandom_range(0, 7)];
            else begin
                code = 5'($urandom);
                if (code == 5'b11100) code = 5'b00000;
            end
            case ($urandom_range(0, 3))
                0:       k = TIMEOUT - 1;
                1:       k = TIMEOUT;
                default: k = $urandom_range(0, TIMEOUT + 2);
            endcase
            issue(1'b0, code, k, "random");
            repeat ($urandom_range(0, 2)) idle(1'b0);
        end

        // Reset in the middle of a read handshake, with ready asserted on the reset edge.
        cur_code = 5'b01100; cur_nm = "rst_mid_ldr";
        step(1'b0, 1'b1, 1'b0, 1'b0, P_WAIT | {19'b0, m_err[0]});
        m_err[0] = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, P_DEC);
        step(1'b0, 1'b0, 1'b0, 1'b0, P_GETA);
        step(1'b0, 1'b0, 1'b0, 1'b0, P_ADDR);
        for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 1'b0, 1'b0, P_MRD);
        step(1'b0, 1'b0, 1'b1, 1'b1, P_MRD);
        m_cnt[0] = '0; m_err[0] = 1'b0;
        idle(1'b0);

        for (int i = 0; i < 256; i++) issue(1'b0, 5'b11010, 0, "wrap_mov");
        idle(1'b0);
        issue(1'b0, 5'b10111, 0, "mvn_after_wrap");

        issue(1'b0, 5'b11100, 0, "halt");
        cur_nm = "halt_hold";
        for (int i = 0; i < 8; i++) begin
            cur_code = 5'($urandom);
            step(1'b0, 1'b1, rb(), 1'b0, P_HALT);
        end
        cur_nm = "halt_reset";
        step(1'b0, 1'b1, rb(), 1'b1, P_HALT);
        m_cnt[0] = '0; m_err[0] = 1'b0;
        idle(1'b0);
        issue(1'b0, 5'b11010, 0, "mov_after_halt");
        idle(1'b0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
